// File: rtl/display_pkg.sv
// Shared seven-segment constants for the calculator display paths.
// Segment codes are ordered {g,f,e,d,c,b,a}, active high.
package display_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/display_ctrl_bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder with a blank override.
// Non-decimal codes (10..15) decode to an unlit digit.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             blank_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_ctrl.sv
// Multiplexed seven-segment display controller: digit buffer with key shift-in,
// parallel load/clear, leading-zero blanking and dead-time digit scanning.
module display_ctrl
    import display_pkg::*;
#(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD        = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       EnableDisp,
    input  logic                       KeyRead,
    input  logic [BCD_W-1:0]           BCDKey,
    input  logic                       Clear,
    input  logic                       Load,
    input  logic [BCD_W*NDIGITS-1:0]   LoadValue,
    output logic [6:0]                 seg,
    output logic [NDIGITS-1:0]         dig,
    output logic [BCD_W*NDIGITS-1:0]   Digits,
    output logic                       Overflow
);

    localparam int BUF_W  = BCD_W * NDIGITS;
    localparam int SCAN_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int PRE_W  = $clog2(REFRESH_DIV);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NDIGITS - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_DEAD  = PRE_W'(DEAD);

    logic               key_q;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic               ovf_q, ovf_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [6:0]         seg_q, seg_d;
    logic [NDIGITS-1:0] dig_q, dig_d;

    logic               key_rise;
    logic [BCD_W-1:0]   top_digit;
    logic [BCD_W-1:0]   sel_digit;
    logic               sel_blank;
    logic [NDIGITS-1:0] blank;

    assign key_rise  = KeyRead & ~key_q;
    assign top_digit = buf_q[BUF_W-1 -: BCD_W];

    // A key edge that coincides with Clear/Load is consumed: key_q still follows KeyRead.
    always_comb begin
        buf_d = buf_q;
        ovf_d = ovf_q;
        if (Clear) begin
            buf_d = '0;
            ovf_d = 1'b0;
        end else if (Load) begin
            buf_d = LoadValue;
            ovf_d = 1'b0;
        end else if (key_rise && (BCDKey <= BCD_W'(9))) begin
            buf_d = {buf_q[BUF_W-BCD_W-1:0], BCDKey};
            if (top_digit != '0) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        scan_d = scan_q;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        blank = '0;
        blank[NDIGITS-1] = (buf_q[BUF_W-1 -: BCD_W] == '0);
        for (int i = NDIGITS - 2; i >= 1; i--) begin
            blank[i] = blank[i+1] && (buf_q[i*BCD_W +: BCD_W] == '0);
        end
        blank[0] = 1'b0;
    end

    always_comb begin
        sel_digit = '0;
        sel_blank = 1'b0;
        dig_d     = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (scan_q == SCAN_W'(i)) begin
                sel_digit = buf_q[i*BCD_W +: BCD_W];
                sel_blank = blank[i];
                if (EnableDisp && (pre_q >= PRE_DEAD)) begin
                    dig_d[i] = 1'b1;
                end
            end
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .digit_i (sel_digit),
        .blank_i (sel_blank),
        .seg_o   (seg_d)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            key_q  <= 1'b0;
            buf_q  <= '0;
            ovf_q  <= 1'b0;
            pre_q  <= '0;
            scan_q <= '0;
            seg_q  <= '0;
            dig_q  <= '0;
        end else begin
            key_q  <= KeyRead;
            buf_q  <= buf_d;
            ovf_q  <= ovf_d;
            pre_q  <= pre_d;
            scan_q <= scan_d;
            seg_q  <= seg_d;
            dig_q  <= dig_d;
        end
    end

    assign seg      = seg_q;
    assign dig      = dig_q;
    assign Digits   = buf_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: stimulus queues the expected display frame,
// a monitor checks each lit digit window against the head of the queue.
`timescale 1ns/1ps
module tb_display_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DD = 2;

    logic        CLK        = 1'b0;
    logic        RESET      = 1'b1;
    logic        EnableDisp = 1'b1;
    logic        KeyRead    = 1'b0;
    logic [3:0]  BCDKey     = 4'd0;
    logic        Clear      = 1'b0;
    logic        Load       = 1'b0;
    logic [15:0] LoadValue  = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic [15:0] Digits;
    logic        Overflow;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic        ovf;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] seen     = 4'd0;
    logic [3:0] prev_dig = 4'd0;

    display_ctrl #(
        .NDIGITS     (ND),
        .REFRESH_DIV (RD),
        .DEAD        (DD)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .EnableDisp (EnableDisp),
        .KeyRead    (KeyRead),
        .BCDKey     (BCDKey),
        .Clear      (Clear),
        .Load       (Load),
        .LoadValue  (LoadValue),
        .seg        (seg),
        .dig        (dig),
        .Digits     (Digits),
        .Overflow   (Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: each start of a lit window is one DUT output event.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            seen <= 4'd0;
        end else if (RESET && (dig != 4'd0) && (prev_dig == 4'd0)) begin
            e = exp_q[0];
            check({e.name, " dig onehot"}, 32'($onehot(dig)), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (dig[i]) begin
                    check($sformatf("%s seg%0d", e.name, i), 32'(seg), 32'(e.segs[i*7 +: 7]));
                end
            end
            check({e.name, " Digits"}, 32'(Digits), 32'(e.digits));
            check({e.name, " Overflow"}, 32'(Overflow), 32'(e.ovf));
            if ((seen | dig) == 4'hF) begin
                void'(exp_q.pop_front());
                seen <= 4'd0;
            end else begin
                seen <= seen | dig;
            end
        end
        prev_dig <= dig;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] k);
        BCDKey  = k;
        KeyRead = 1'b1;
        tick(5);
        KeyRead = 1'b0;
        tick(3);
    endtask

    task automatic load(input logic [15:0] v);
        LoadValue = v;
        Load      = 1'b1;
        tick(1);
        Load      = 1'b0;
    endtask

    task automatic expect_disp(input string name, input logic [15:0] d, input logic o,
                               input logic [27:0] s);
        exp_t e;
        e.name   = name;
        e.digits = d;
        e.ovf    = o;
        e.segs   = s;
        tick(2);
        exp_q.push_back(e);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick(1);
        if (exp_q.size() != 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL %s timeout: saw slots 0x%0h, expected all 4 slots lit", name, seen);
            exp_q.delete();
        end
    endtask

    task automatic wait_lit(input string name);
        int t;
        t = 0;
        while (dig == 4'd0 && t < 40) begin
            tick(1);
            t++;
        end
        if (dig == 4'd0) begin
            nchecks++;
            nerrors++;
            $display("FAIL %s: got dig=0 for 40 cycles, expected a lit digit", name);
        end
    endtask

    initial begin
        int         zeros;
        int         lit;
        logic [3:0] d0;

        #1 RESET = 1'b0;
        tick(2);
        check("reset seg", 32'(seg), 32'h0);
        check("reset dig", 32'(dig), 32'h0);
        check("reset Digits", 32'(Digits), 32'h0);
        check("reset Overflow", 32'(Overflow), 32'h0);
        RESET = 1'b1;

        expect_disp("idle", 16'h0000, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F});

        zeros = 0;
        repeat (32) begin
            tick(1);
            if (dig == 4'd0) zeros++;
        end
        check("dead cycles per 32", 32'(zeros), 32'd8);

        press(4'd1);
        press(4'd2);
        press(4'd3);
        expect_disp("keys123", 16'h0123, 1'b0, {7'h00, 7'h06, 7'h5B, 7'h4F});

        press(4'd4);
        press(4'd5);
        expect_disp("keys45 overflow", 16'h2345, 1'b1, {7'h5B, 7'h4F, 7'h66, 7'h6D});

        press(4'hA);
        expect_disp("operator key", 16'h2345, 1'b1, {7'h5B, 7'h4F, 7'h66, 7'h6D});

        load(16'h0907);
        expect_disp("load 0907", 16'h0907, 1'b0, {7'h00, 7'h6F, 7'h3F, 7'h07});

        load(16'h00A1);
        expect_disp("load non-decimal", 16'h00A1, 1'b0, {7'h00, 7'h00, 7'h00, 7'h06});

        LoadValue = 16'h0456;
        Load      = 1'b1;
        BCDKey    = 4'd8;
        KeyRead   = 1'b1;
        tick(1);
        Load      = 1'b0;
        tick(4);
        KeyRead   = 1'b0;
        tick(2);
        expect_disp("load beats key", 16'h0456, 1'b0, {7'h00, 7'h66, 7'h6D, 7'h7D});

        press(4'd1);
        press(4'd2);
        expect_disp("shift out 4", 16'h5612, 1'b1, {7'h6D, 7'h7D, 7'h06, 7'h5B});

        LoadValue = 16'h1111;
        Clear     = 1'b1;
        Load      = 1'b1;
        tick(1);
        Clear     = 1'b0;
        Load      = 1'b0;
        expect_disp("clear beats load", 16'h0000, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F});

        load(16'h0123);
        tick(2);
        wait_lit("enable setup");
        d0         = dig;
        EnableDisp = 1'b0;
        lit = 0;
        repeat (20) begin
            tick(1);
            if (dig != 4'd0) lit++;
        end
        check("disabled lit cycles", 32'(lit), 32'd0);
        EnableDisp = 1'b1;
        tick(12);
        check("scan phase kept", 32'(dig), 32'(d0));

        wait_lit("reset setup");
        #2;
        KeyRead = 1'b1;
        BCDKey  = 4'd7;
        RESET   = 1'b0;
        #1;
        check("async reset seg", 32'(seg), 32'h0);
        check("async reset dig", 32'(dig), 32'h0);
        check("async reset Digits", 32'(Digits), 32'h0);
        check("async reset Overflow", 32'(Overflow), 32'h0);
        tick(2);
        RESET = 1'b1;
        wait_lit("restart");
        check("restart slot", 32'(dig), 32'h1);
        expect_disp("key held at reset release", 16'h0007, 1'b0, {7'h00, 7'h00, 7'h00, 7'h07});
        KeyRead = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Multiplexed seven-segment display controller for the calculator: the output-side counterpart of the keypad scanner. Captures digit key codes as they are read, shifting each new digit in from the right. Also accepts parallel loads of a result and clears. Time-multiplexes the digit buffer onto a common-cathode display, with leading-zero blanking and anti-ghosting dead time. Sits between the keypad controller / top-level FSM and the display pins.

## Interface
- NDIGITS, 4, number of display digits (2..8)
- REFRESH_DIV, 1024, CLK cycles per digit slot (>= 4)
- DEAD, 2, cycles at slot start with all digit selects off (< REFRESH_DIV)

Ports:
- CLK  in  1  single system clock, rising edge
- RESET  in  1  asynchronous, active-low; RESET=0 clears all state immediately
- EnableDisp  in  1  1 = display driven; 0 = dig held all-zero (buffer still updates)
- KeyRead  in  1  level from keypad controller, high while a key is held; same clock domain
- BCDKey  in  4  key code, valid while KeyRead=1
- Clear  in  1  synchronous buffer clear
- Load  in  1  synchronous parallel load strobe
- LoadValue  in  4*NDIGITS  digit values, digit 0 in bits [3:0]
- seg  out  7  segments {g,f,e,d,c,b,a}, active high, registered
- dig  out  NDIGITS  one-hot digit select, active high, registered
- Digits  out  4*NDIGITS  current buffer contents, digit 0 = least significant
- Overflow  out  1  sticky; set when a shift discards a nonzero top digit

## Operation
- Key capture: rising edge of KeyRead (registered previous value 0, current value 1) with BCDKey <= 9 -> buffer shifts left one digit; BCDKey enters digit 0; digit NDIGITS-1 is discarded. BCDKey 10..15 (operator keys): no shift. A held key produces exactly one shift.
- Overflow is set on a shift whose discarded digit is nonzero. It is cleared only by Clear, Load or reset.
- Priority in one cycle: Clear > Load > key shift. Clear: buffer = 0, Overflow = 0. Load: buffer = LoadValue, Overflow = 0.
- Scan: prescaler counts 0..REFRESH_DIV-1. At terminal count, the scan index advances; it wraps from NDIGITS-1 to 0.
- Drive: during prescaler 0..DEAD-1, dig = 0. Otherwise dig = one-hot(scan index) if EnableDisp = 1, else 0.
- seg is the segment code of the selected digit, or 0 when that digit is blanked.
- Blanking: digit i (i > 0) is blanked when digits i..NDIGITS-1 are all zero. Digit 0 is never blanked. Digit values 10..15 (possible only via Load) display as 0x00.
- Segment codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.

## Timing
- Reset values: seg=0, dig=0, Digits=0, Overflow=0, scan index 0, prescaler 0, KeyRead edge register 0.
- Key edge sampled at clock n -> Digits/Overflow updated after clock n.
- Clear/Load sampled at clock n -> Digits updated after clock n.
- seg/dig are registered from the current buffer. A buffer change appears on pins one cycle later, in the slot currently being scanned.
- Full refresh period = NDIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-DEAD cycles per period.
- Key edge coincident with Clear or Load: the edge is consumed and lost. A level still high afterwards does not re-trigger.
- KeyRead already high when RESET deasserts: counts as an edge (edge register resets to 0).
- RESET asserted mid-slot: outputs go to reset values asynchronously. Scanning restarts at digit 0, prescaler 0.
- EnableDisp toggling does not disturb the prescaler or scan index.

## Structure
- Shared package display_pkg: the segment-code constants for 0..9, SEG_BLANK = 7'h00, and the BCD digit width constant (4).
- One combinational sub-module bcd_to_seg (4-bit digit + blank flag -> 7-bit seg), reusable by other display paths.
- The top of display_ctrl holds the buffer/shift logic, prescaler, scan counter and output registers.

## Test plan
Parameters: NDIGITS=4, REFRESH_DIV=8, DEAD=2.
- Reset then idle: Digits=0x0000. Only digit 0 is lit, with seg=0x3F. Slots 1..3 show seg=0. dig is 0 for 2 of every 8 cycles.
- Keys 1,2,3 (KeyRead pulses, each held 5 cycles) -> Digits=0x0123. Digit 3 is blanked; digits 2,1,0 show 0x06, 0x5B, 0x4F. Each key shifts exactly once.
- Keys 4,5 after 0x0123 -> Digits=0x2345, Overflow=1. BCDKey=0xA with an edge -> Digits unchanged.
- Load with LoadValue=0x0907 -> Digits=0x0907, Overflow=0. Digit 3 is blanked; digit 1 (value 0) shows 0x3F because a higher digit is nonzero.
- Load and a key edge in the same cycle -> the LoadValue wins and the key is ignored. Clear and Load together -> Digits=0.
- EnableDisp=0 for 20 cycles -> dig=0 throughout; scan phase continues. RESET=0 mid-slot -> all outputs 0 asynchronously.
